// File: rtl/saturate_if.sv
// Clamp-stage bus: input sample with its qualifier, and the registered
// clamped result with its clip flags.
interface saturate_if #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             sat_hi;
    logic             sat_lo;

    // Upstream stage drives samples and observes the clamped result.
    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data,
        input  sat_hi,
        input  sat_lo
    );

    // The clamp itself.
    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data,
        output sat_hi,
        output sat_lo
    );
endinterface

// File: rtl/saturate.sv
// Unsigned output clamp with one register stage and clip flags.
// Define SATURATE_STATS_EN to add a sticky 16-bit clipped-sample counter.
module saturate #(
    parameter int IN_W      = 10,
    parameter int OUT_W     = 8,
    parameter bit SIGNED_IN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    saturate_if.slave   bus
`ifdef SATURATE_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [15:0] stat_count
`endif
);

    logic [OUT_W-1:0] clamp_data;
    logic             clip_hi;
    logic             clip_lo;

    // Any set bit above the output range means the value exceeds MAX; in
    // signed mode the sign bit is tested first so this only sees positives.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        clamp_data = bus.in_data[OUT_W-1:0];
        clip_hi    = 1'b0;
        clip_lo    = 1'b0;
        if (SIGNED_IN && bus.in_data[IN_W-1]) begin
            clamp_data = '0;
            clip_lo    = 1'b1;
        end else if (|bus.in_data[IN_W-1:OUT_W]) begin
            clamp_data = '1;
            clip_hi    = 1'b1;
        end
    end

    // Data and flags only move on a valid sample so downstream sees the
    // last result held while the stream idles.
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.sat_hi    <= 1'b0;
            bus.sat_lo    <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out_data <= clamp_data;
                bus.sat_hi   <= clip_hi;
                bus.sat_lo   <= clip_lo;
            end
        end
    end

`ifdef SATURATE_STATS_EN
    logic [15:0] clip_count;

    // Clear wins over a coincident clipped sample; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            clip_count <= '0;
        end else if (bus.in_valid && (clip_hi || clip_lo) && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end
    end

    assign stat_count = clip_count;
`endif

endmodule

// File: tb/tb_saturate.sv
// Scoreboard bench for saturate: an unsigned and a signed instance share
// one random stimulus stream and are checked against an arithmetic model.
module tb_saturate;

    localparam int IN_W  = 10;
    localparam int OUT_W = 8;
    localparam int MAX   = (1 << OUT_W) - 1;

    typedef struct {
        int data;
        bit hi;
        bit lo;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic [IN_W-1:0] in_data = '0;
`ifdef SATURATE_STATS_EN
    logic            stat_clr = 1'b0;
    logic [15:0]     stat_count_u;
    logic [15:0]     stat_count_s;
    int              cnt_m [2] = '{0, 0};
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t q_u[$];
    exp_t q_s[$];
    exp_t hold [2];
    logic rst_q = 1'b1;
    logic vld_q = 1'b0;
    bit   started = 1'b0;

    saturate_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus_u ();
    saturate_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus_s ();

    assign bus_u.in_valid = in_valid;
    assign bus_u.in_data  = in_data;
    assign bus_s.in_valid = in_valid;
    assign bus_s.in_data  = in_data;

    saturate #(.IN_W(IN_W), .OUT_W(OUT_W), .SIGNED_IN(1'b0)) u_dut_u (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_u)
`ifdef SATURATE_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_count (stat_count_u)
`endif
    );

    saturate #(.IN_W(IN_W), .OUT_W(OUT_W), .SIGNED_IN(1'b1)) u_dut_s (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_s)
`ifdef SATURATE_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_count (stat_count_s)
`endif
    );

    always #5 clk = ~clk;

    // Reference: interpret the raw value as an integer, then clamp to 0..MAX.
    function automatic exp_t ref_model(input int raw, input bit signed_mode);
        exp_t e;
        int   val;
        val = raw;
        if (signed_mode && raw >= (1 << (IN_W - 1))) val = raw - (1 << IN_W);
        e.hi = 1'b0;
        e.lo = 1'b0;
        if (val < 0) begin
            e.data = 0;
            e.lo   = 1'b1;
        end else if (val > MAX) begin
            e.data = MAX;
            e.hi   = 1'b1;
        end else begin
            e.data = val;
        end
        return e;
    endfunction

    function automatic bit clipped(input int raw, input bit signed_mode);
        exp_t e;
        e = ref_model(raw, signed_mode);
        return e.hi || e.lo;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        started <= 1'b1;
        rst_q   <= reset;
        vld_q   <= in_valid;
`ifdef SATURATE_STATS_EN
        for (int m = 0; m < 2; m++) begin
            if (reset || stat_clr) cnt_m[m] <= 0;
            else if (in_valid && clipped(int'(in_data), m[0])) cnt_m[m] <= (cnt_m[m] >= 65535) ? 65535 : cnt_m[m] + 1;
        end
`endif
    end

    task automatic mon(input int m, input logic ov, input logic [OUT_W-1:0] od, input logic hi, input logic lo);
        string p;
        exp_t  e;
        p = (m == 0) ? "u" : "s";
        if (rst_q) begin
            check({p, "_rst_valid"}, 32'(ov), 0);
            check({p, "_rst_data"}, 32'(od), 0);
            check({p, "_rst_hi"}, 32'(hi), 0);
            check({p, "_rst_lo"}, 32'(lo), 0);
            hold[m] = '{data: 0, hi: 1'b0, lo: 1'b0};
        end else begin
            check({p, "_valid"}, 32'(ov), 32'(vld_q));
            if (ov === 1'b1) begin
                if ((m == 0 ? q_u.size() : q_s.size()) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s_unexpected_output: got data %0d expected no output", p, od);
                end else begin
                    e = (m == 0) ? q_u.pop_front() : q_s.pop_front();
                    hold[m] = e;
                end
            end
            check({p, "_data"}, 32'(od), 32'(hold[m].data));
            check({p, "_hi"}, 32'(hi), 32'(hold[m].hi));
            check({p, "_lo"}, 32'(lo), 32'(hold[m].lo));
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            mon(0, bus_u.out_valid, bus_u.out_data, bus_u.sat_hi, bus_u.sat_lo);
            mon(1, bus_s.out_valid, bus_s.out_data, bus_s.sat_hi, bus_s.sat_lo);
            check("hi_lo_exclusive_u", 32'(bus_u.sat_hi & bus_u.sat_lo), 0);
            check("hi_lo_exclusive_s", 32'(bus_s.sat_hi & bus_s.sat_lo), 0);
`ifdef SATURATE_STATS_EN
            check("u_stat_count", 32'(stat_count_u), 32'(cnt_m[0]));
            check("s_stat_count", 32'(stat_count_s), 32'(cnt_m[1]));
`endif
        end
    end

    // Inputs change 1 ns after the edge; the following edge captures them.
    task automatic drive(input bit v, input int d, input bit r, input bit c);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d[IN_W-1:0];
        reset    = r;
`ifdef SATURATE_STATS_EN
        stat_clr = c;
`endif
        if (v && !r) begin
            q_u.push_back(ref_model(d & ((1 << IN_W) - 1), 1'b0));
            q_s.push_back(ref_model(d & ((1 << IN_W) - 1), 1'b1));
        end
    endtask

    initial begin
        int edge_vals [6];
        int sel;
        edge_vals = '{255, 256, 511, 512, 0, 1023};

        drive(0, 0, 1, 1);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);

        foreach (edge_vals[i]) drive(1, (i < 5) ? int'(edge_vals[i]) : 304, 0, 0);
        drive(1, 200, 0, 0);
        drive(1, 1023, 0, 0);
        drive(1, 'h3FF, 0, 0);
        drive(1, 'h200, 0, 0);
        drive(1, 'h0FF, 0, 0);
        drive(1, 'h1FF, 0, 0);

        drive(1, 100, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 500, 0, 0);

        drive(1, 300, 1, 0);
        drive(0, 0, 0, 0);
        drive(1, 50, 0, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("post_reset_sample", 32'(bus_u.out_data), 50);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 7);
            drive($urandom_range(0, 3) != 0,
                  (sel < 6) ? edge_vals[sel] : int'($urandom_range(0, (1 << IN_W) - 1)),
                  $urandom_range(0, 49) == 0,
                  $urandom_range(0, 19) == 0);
        end

`ifdef SATURATE_STATS_EN
        drive(0, 0, 0, 1);
        drive(1, 300, 0, 0);
        drive(1, 10, 0, 0);
        drive(1, 400, 0, 0);
        drive(1, 20, 0, 0);
        drive(1, 1000, 0, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("stat_three_clips", 32'(stat_count_u), 3);
        drive(1, 300, 0, 1);
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("stat_clr_wins", 32'(stat_count_u), 0);
        for (int i = 0; i < 70000; i++) drive(1, 1023, 0, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("stat_sticky_max", 32'(stat_count_u), 32'hFFFF);
`endif

        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
        @(negedge clk);
        check("u_queue_drained", 32'(q_u.size()), 0);
        check("s_queue_drained", 32'(q_s.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
